// File: rtl/irq_aggregator_if.sv
// ---------------------------------------------------------------------------
// irq_aggregator_if
//   Avalon-MM register port of the interrupt aggregator (timer-slave style).
//
//   Signals:
//     chipselect  slave select
//     address     3-bit word address
//     write_n     active-low write strobe, qualified by chipselect
//     writedata   16-bit write data
//     readdata    16-bit registered read data
//
//   Handshake: there is no valid/ready pair and no wait state. Every cycle
//   with chipselect high is a transfer; it is a write when write_n is low.
//   readdata is loaded from the address on every clock, so the value for an
//   address presented in cycle c is available after the following edge.
//
//   Modports: master drives the request and samples readdata; slave is the
//   aggregator side.
// ---------------------------------------------------------------------------
interface irq_aggregator_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/irq_aggregator.sv
// ---------------------------------------------------------------------------
// irq_aggregator
//   Collects NUM_IRQ peripheral interrupt lines, synchronizes them, latches
//   them into PENDING, gates with MASK and a global enable, and drives one
//   registered CPU interrupt plus a lowest-index VECTOR register.
//
//   Ports:
//     clk       system clock
//     reset_n   asynchronous active-low reset
//     bus       irq_aggregator_if.slave register port
//     irq_in    NUM_IRQ level interrupt sources (may be asynchronous)
//     irq_out   registered CPU interrupt
//
//   Register map (word address):
//     0 PENDING  read / write-1-to-clear
//     1 MASK     read/write
//     2 RAW      synchronized irq_in (read-only)
//     3 ACTIVE   PENDING & MASK (read-only)
//     4 VECTOR   bit 15 valid, bits 3:0 lowest active index (read-only)
//     5 SWSET    write-1-to-set PENDING, reads 0
//     6 CONTROL  bit 0 GIE
//     7 reserved, reads 0
//
//   Build option IRQ_EDGE_DETECT_EN:
//     defined   - PENDING is sticky, set on the rising edge of the
//                 synchronized line or by SWSET, cleared by write-1.
//     undefined - level mode: PENDING is the synchronized line OR a sticky
//                 software-set register; write-1 clears only the software
//                 bits.
// ---------------------------------------------------------------------------
module irq_aggregator #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    irq_aggregator_if.slave    bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_RAW     = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_SWSET   = 3'd5;
    localparam logic [2:0] ADDR_CONTROL = 3'd6;

    logic               wr_en;
    logic [NUM_IRQ-1:0] wdata_bits;
    logic [NUM_IRQ-1:0] clr_bits;
    logic [NUM_IRQ-1:0] set_bits;
    logic [NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] raw_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] active;
    logic               gie_q;
    logic [15:0]        vector;
    logic [15:0]        rd_mux;
    logic               unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata_bits   = bus.writedata[NUM_IRQ-1:0];
    // Upper writedata bits are intentionally ignored for NUM_IRQ < 16.
    assign unused_wdata = ^bus.writedata;

    assign clr_bits = (wr_en && bus.address == ADDR_PENDING) ? wdata_bits : '0;
    assign set_bits = (wr_en && bus.address == ADDR_SWSET)   ? wdata_bits : '0;
    assign active   = pending_q & mask_q;

    // Two-flop synchronizer; raw_q is the usable, metastability-free copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            raw_q  <= '0;
        end else begin
            sync_q <= irq_in;
            raw_q  <= sync_q;
        end
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] raw_d_q;

    // Set terms are ORed in after the clear so a coincident set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_d_q   <= '0;
            pending_q <= '0;
        end else begin
            raw_d_q   <= raw_q;
            pending_q <= (pending_q & ~clr_bits) | (raw_q & ~raw_d_q) | set_bits;
        end
    end
`else
    logic [NUM_IRQ-1:0] swset_q;
    logic [NUM_IRQ-1:0] swset_next;

    assign swset_next = (swset_q & ~clr_bits) | set_bits;

    // PENDING tracks the synchronized lines directly; only the software
    // bits are sticky. Registering it keeps the same source-to-irq_out
    // latency as edge mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swset_q   <= '0;
            pending_q <= '0;
        end else begin
            swset_q   <= swset_next;
            pending_q <= raw_q | swset_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            gie_q  <= 1'b0;
        end else if (wr_en) begin
            if (bus.address == ADDR_MASK) begin
                mask_q <= wdata_bits;
            end
            if (bus.address == ADDR_CONTROL) begin
                gie_q <= bus.writedata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_out <= 1'b0;
        end else begin
            irq_out <= gie_q & (|active);
        end
    end

    // Scan downward so the lowest set bit is the last assignment.
    always_comb begin
        vector = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                vector[3:0] = 4'(i);
                vector[15]  = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_PENDING: rd_mux[NUM_IRQ-1:0] = pending_q;
            ADDR_MASK:    rd_mux[NUM_IRQ-1:0] = mask_q;
            ADDR_RAW:     rd_mux[NUM_IRQ-1:0] = raw_q;
            ADDR_ACTIVE:  rd_mux[NUM_IRQ-1:0] = active;
            ADDR_VECTOR:  rd_mux = vector;
            ADDR_CONTROL: rd_mux[0] = gie_q;
            default:      rd_mux = '0;
        endcase
    end

    // Loaded every clock regardless of chipselect, as the timer slaves do.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: doc/irq_aggregator.md
# irq_aggregator

Avalon-MM slave interrupt aggregator that sits directly downstream of the system's interval timers and other peripherals. It collects up to 16 peripheral `irq` lines and synchronizes them, then latches them into a pending register. Each pending bit is gated by a per-source mask, and the block drives one registered interrupt to the CPU together with a vector register holding the lowest-numbered active source. Its register access style matches the timer slaves: 3-bit word address, 16-bit data, and registered readdata.

## Interface
- `NUM_IRQ`, default 8: number of interrupt sources, legal range 1..16. Unused register bits read 0.
- `clk  in  1`: system clock.
- `reset_n  in  1`: asynchronous, active-low reset.
- `chipselect  in  1`: slave select.
- `address  in  3`: word address.
- `write_n  in  1`: active-low write strobe, qualified by `chipselect`.
- `writedata  in  16`: write data.
- `readdata  out  16`: registered read data. Resets to 0.
- `irq_in  in  NUM_IRQ`: source interrupt lines, level, possibly asynchronous.
- `irq_out  out  1`: registered CPU interrupt. Resets to 0.

## Operation
- Register map:
  - 0 PENDING: read, or write-1-to-clear.
  - 1 MASK: read/write. Reset 0.
  - 2 RAW: read-only; synchronized `irq_in`.
  - 3 ACTIVE: read-only; PENDING & MASK.
  - 4 VECTOR: read-only. Bit 15 = valid (ACTIVE != 0). Bits 3:0 = index of the lowest set ACTIVE bit. All zero when ACTIVE is 0.
  - 5 SWSET: write-1-to-set PENDING. Reads 0.
  - 6 CONTROL: bit 0 is GIE (global interrupt enable). Reset 0. Other bits read 0.
  - 7: reserved. Reads 0; writes are ignored.
- Writes to read-only addresses have no effect. Only `writedata[NUM_IRQ-1:0]` is used for MASK, PENDING and SWSET.
- Synchronizer: two flops per source, reset to 0. Output is `raw`.
- Pending set sources: the rising edge of `raw` (edge mode, see Configuration) and SWSET writes.
- Simultaneous set and clear on the same bit in the same cycle: set wins, so no event is lost.
- `irq_out` next state = GIE & |(PENDING & MASK), registered.
- `readdata` follows the timer convention: `readdata <= mux(address)` every clock, whether or not `chipselect` is asserted.
- Reset mid-operation clears synchronizers, PENDING, MASK, GIE, `readdata` and `irq_out` immediately. No pending event survives reset.

## Timing
- `irq_in` is first sampled high at clock edge k:
  - sync stage 2 is high after edge k+1;
  - PENDING is set at edge k+2;
  - `irq_out` rises at edge k+3.
- Write to PENDING, MASK, SWSET or CONTROL at edge w: the register updates at w, and `irq_out` reflects the change at w+1.
- Read: `address` is presented in cycle c, and `readdata` is valid after edge c+1 (one cycle latency). There are no wait states.
- A read in the same cycle as a write returns the pre-write value.
- VECTOR is combinational from registered state. When read, it reflects PENDING and MASK as of the cycle the address is presented.

## Configuration
- `IRQ_EDGE_DETECT_EN` defined:
  - PENDING bits are sticky. They are set on the rising edge of `raw` or by SWSET, and cleared only by a write-1-to-clear.
  - A source held high sets PENDING once only.
- `IRQ_EDGE_DETECT_EN` undefined (level mode):
  - PENDING = `raw` | swset, where swset is a sticky software-set register.
  - Write-1-to-clear clears only the swset bits.
  - PENDING follows `raw` with no edge-capture flops. This matches peripherals such as the interval timer, which hold `irq` until their own status register is cleared.

## Test plan
- Reset then read:
  - Stimulus: reset, then read addresses 0..7.
  - Required: all reads return 0x0000, and `irq_out` = 0.
- Basic interrupt path:
  - Stimulus: MASK = 0x0004, CONTROL = 0x0001, then raise `irq_in[2]` at edge k.
  - Required: `irq_out` = 1 at edge k+3; VECTOR reads 0x8002; ACTIVE reads 0x0004.
- Priority and mask:
  - Stimulus: raise `irq_in[5]` and `irq_in[1]` with MASK = 0x00FF.
  - Required: VECTOR reads 0x8001.
  - Stimulus: then MASK = 0x00FD.
  - Required: VECTOR reads 0x8005.
- Edge mode clear (`IRQ_EDGE_DETECT_EN`):
  - Stimulus: hold `irq_in[0]` high, then write 0x0001 to PENDING.
  - Required: PENDING reads 0 and `irq_out` falls one cycle after the write.
  - Stimulus: drop and re-raise `irq_in[0]`.
  - Required: PENDING bit 0 is set again.
- Simultaneous clear and edge:
  - Stimulus: W1C of bit 3 in the same cycle that the `raw[3]` rising edge is detected.
  - Required: PENDING bit 3 remains 1.
- Software trigger and gating:
  - Stimulus: write 0x0080 to SWSET with MASK = 0x0080 and GIE = 0.
  - Required: PENDING = 0x0080 and `irq_out` stays 0.
  - Stimulus: set GIE.
  - Required: `irq_out` = 1 one cycle later.
  - Stimulus: assert `reset_n` low mid-stream.
  - Required: all registers and outputs go to 0 asynchronously.
